// File: rtl/bcd_stopwatch.sv
// BCD mm:ss stopwatch core driven by one-cycle tick enables, with up/down
// counting, per-field adjust, pause toggle, lap display freeze and a wrap pulse.
module bcd_stopwatch #(
    parameter int MIN_MAX = 99,
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       lap,
    input  logic       adj,
    input  logic       sel,
    input  logic       dir,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       paused,
    output logic       lap_active,
    output logic       wrap
);

    generate
        if (MIN_MAX < 1 || MIN_MAX > 99 || SEC_MAX < 1 || SEC_MAX > 59) begin : g_bad_param
            $fatal(1, "bcd_stopwatch: MIN_MAX must be 1..99 and SEC_MAX 1..59");
        end
    endgenerate

    localparam logic [3:0] MIN_T_MAX = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_O_MAX = 4'(MIN_MAX % 10);
    localparam logic [3:0] SEC_T_MAX = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_O_MAX = 4'(SEC_MAX % 10);

    // Steps a two-digit BCD field by one within 0..max; bit 8 flags the wrap.
    function automatic logic [8:0] bcd_step(input logic [3:0] t, input logic [3:0] o,
                                            input logic [3:0] max_t, input logic [3:0] max_o,
                                            input logic down);
        logic [8:0] r;
        r = {1'b0, t, o};
        if (!down) begin
            if (t == max_t && o == max_o) begin
                r = {1'b1, 4'd0, 4'd0};
            end else if (o == 4'd9) begin
                r = {1'b0, t + 4'd1, 4'd0};
            end else begin
                r = {1'b0, t, o + 4'd1};
            end
        end else begin
            if (t == 4'd0 && o == 4'd0) begin
                r = {1'b1, max_t, max_o};
            end else if (o == 4'd0) begin
                r = {1'b0, t - 4'd1, 4'd9};
            end else begin
                r = {1'b0, t, o - 4'd1};
            end
        end
        return r;
    endfunction

    // Digit vectors are packed {min_t, min_o, sec_t, sec_o}.
    logic [15:0] live_r, snap_r, disp_r;
    logic        paused_r, lap_active_r, wrap_r, pause_q_r, lap_q_r;

    logic [15:0] live_s, snap_s, disp_s;
    logic        paused_s, lap_active_s, wrap_s;
    logic        tick_s, step_s, pause_rise_s, lap_rise_s;
    logic [8:0]  sec_step_s, min_step_s;

    // Next-state: count/adjust step, pause and lap toggles, display select.
    always_comb begin
        tick_s       = adj ? tick_2hz : tick_1hz;
        step_s       = tick_s & ~paused_r;
        pause_rise_s = pause & ~pause_q_r;
        lap_rise_s   = lap & ~lap_q_r;
        sec_step_s   = bcd_step(live_r[7:4], live_r[3:0], SEC_T_MAX, SEC_O_MAX, dir);
        min_step_s   = bcd_step(live_r[15:12], live_r[11:8], MIN_T_MAX, MIN_O_MAX, dir);
        live_s       = live_r;
        wrap_s       = 1'b0;

        if (step_s) begin
            if (adj) begin
                if (sel) begin
                    live_s[7:0] = sec_step_s[7:0];
                end else begin
                    live_s[15:8] = min_step_s[7:0];
                end
            end else begin
                live_s[7:0] = sec_step_s[7:0];
                if (sec_step_s[8]) begin
                    live_s[15:8] = min_step_s[7:0];
                    wrap_s       = min_step_s[8];
                end else begin
                    live_s[15:8] = live_r[15:8];
                end
            end
        end else begin
            live_s = live_r;
        end

        paused_s     = paused_r ^ pause_rise_s;
        lap_active_s = lap_active_r ^ lap_rise_s;
        // The snapshot takes the already-stepped value so a same-edge tick is kept.
        if (lap_rise_s && !lap_active_r) begin
            snap_s = live_s;
        end else begin
            snap_s = snap_r;
        end
        disp_s = lap_active_s ? snap_s : live_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_r       <= 16'h0000;
            snap_r       <= 16'h0000;
            disp_r       <= 16'h0000;
            paused_r     <= 1'b0;
            lap_active_r <= 1'b0;
            wrap_r       <= 1'b0;
            pause_q_r    <= 1'b0;
            lap_q_r      <= 1'b0;
        end else begin
            live_r       <= live_s;
            snap_r       <= snap_s;
            disp_r       <= disp_s;
            paused_r     <= paused_s;
            lap_active_r <= lap_active_s;
            wrap_r       <= wrap_s;
            pause_q_r    <= pause;
            lap_q_r      <= lap;
        end
    end

    assign min_t      = disp_r[15:12];
    assign min_o      = disp_r[11:8];
    assign sec_t      = disp_r[7:4];
    assign sec_o      = disp_r[3:0];
    assign paused     = paused_r;
    assign lap_active = lap_active_r;
    assign wrap       = wrap_r;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: default instance plus a MIN_MAX=1 instance.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0, pause = 1'b0, lap = 1'b0;
    logic adj = 1'b0, sel = 1'b0, dir = 1'b0;

    logic [3:0] a_min_t, a_min_o, a_sec_t, a_sec_o;
    logic       a_paused, a_lap_active, a_wrap;
    logic [3:0] b_min_t, b_min_o, b_sec_t, b_sec_o;
    logic       b_paused, b_lap_active, b_wrap;

    always #5 clk = ~clk;

    bcd_stopwatch dut_a (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause(pause), .lap(lap), .adj(adj), .sel(sel), .dir(dir),
        .min_t(a_min_t), .min_o(a_min_o), .sec_t(a_sec_t), .sec_o(a_sec_o),
        .paused(a_paused), .lap_active(a_lap_active), .wrap(a_wrap)
    );

    bcd_stopwatch #(.MIN_MAX(1), .SEC_MAX(59)) dut_b (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause(pause), .lap(lap), .adj(adj), .sel(sel), .dir(dir),
        .min_t(b_min_t), .min_o(b_min_o), .sec_t(b_sec_t), .sec_o(b_sec_o),
        .paused(b_paused), .lap_active(b_lap_active), .wrap(b_wrap)
    );

    wire [15:0] a_dig = {a_min_t, a_min_o, a_sec_t, a_sec_o};
    wire [15:0] b_dig = {b_min_t, b_min_o, b_sec_t, b_sec_o};
    wire [2:0]  a_fl  = {a_paused, a_lap_active, a_wrap};
    wire [2:0]  b_fl  = {b_paused, b_lap_active, b_wrap};

    typedef struct {
        logic        b;
        logic [15:0] dig;
        logic [2:0]  fl;
        string       name;
    } exp_t;

    typedef struct {
        logic  t1, t2, a, sl, d;
        int    m, s;
        string name;
    } vec_t;

    exp_t sb[$];
    vec_t vt[14];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // flags = {paused, lap_active, wrap}
    task automatic push(input logic b, input int m, input int s, input logic [2:0] fl,
                        input string name);
        exp_t e;
        e.b = b; e.dig = bcd(m, s); e.fl = fl; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        logic [15:0] d;
        logic [2:0]  f;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d = e.b ? b_dig : a_dig;
            f = e.b ? b_fl : a_fl;
            checks++;
            if (d !== e.dig || f !== e.fl) begin
                errors++;
                $display("FAIL %s: got digits %h flags %b, want digits %h flags %b",
                         e.name, d, f, e.dig, e.fl);
            end
        end
    endtask

    task automatic cyc(input logic t1, input logic t2, input logic p, input logic l);
        tick_1hz = t1; tick_2hz = t2; pause = p; lap = l;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; tick_2hz = 1'b0;
        check_sb();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        pause = 1'b0; lap = 1'b0; adj = 1'b0; sel = 1'b0; dir = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Asserts rst between edges and checks outputs before the next edge.
    task automatic mid_reset(input string name);
        rst = 1'b1;
        #2;
        push(1'b0, 0, 0, 3'b000, name);
        check_sb();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1,  0, "adj_min_up_1"};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  2,  0, "adj_min_up_2"};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  2, 59, "adj_sec_down_wrap"};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  2, 58, "adj_sec_down"};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  2, 59, "adj_sec_up_59"};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  2,  0, "adj_sec_no_carry"};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  2,  1, "adj_sec_up_01"};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  2,  1, "adj_ignores_1hz"};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1,  1, "adj_min_down_1"};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  0,  1, "adj_min_down_0"};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 99,  1, "adj_min_down_wrap"};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 99,  1, "normal_ignores_2hz"};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 99,  2, "normal_up_after_adj"};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 99,  1, "normal_down_after_adj"};

        // Reset state and reset mid-count
        @(posedge clk);
        #1;
        do_reset();
        push(1'b0, 0, 0, 3'b000, "reset_state_a");
        push(1'b1, 0, 0, 3'b000, "reset_state_b");
        check_sb();
        ticks(6);
        push(1'b0, 0, 7, 3'b000, "count_to_07");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        mid_reset("reset_async");
        push(1'b0, 0, 1, 3'b000, "first_tick_after_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Up wrap on the MIN_MAX=1 instance, back-to-back ticks
        do_reset();
        ticks(118);
        push(1'b1, 1, 59, 3'b000, "b_tick119");
        push(1'b0, 1, 59, 3'b000, "a_tick119");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 0, 0, 3'b001, "b_up_wrap");
        push(1'b0, 2, 0, 3'b000, "a_min_carry");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 0, 0, 3'b000, "b_wrap_drops");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Down count and wrap from 00:00
        do_reset();
        dir = 1'b1;
        push(1'b0, 99, 59, 3'b001, "a_down_wrap");
        push(1'b1, 1, 59, 3'b001, "b_down_wrap");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 99, 59, 3'b000, "a_down_wrap_drops");
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 99, 58, 3'b000, "a_down_step");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        dir = 1'b0;

        // Pause
        do_reset();
        ticks(2);
        push(1'b0, 0, 3, 3'b000, "pause_pre_03");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 3, 3'b100, "pause_toggle");
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b0, 0, 3, 3'b100, "pause_single_toggle");
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 3, 3'b100, "paused_ticks_ignored");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 3, 3'b000, "resume");
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 4, 3'b000, "resumed_tick");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 5, 3'b100, "tick_press_running");
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 5, 3'b000, "tick_press_paused");
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Adjust mode table; mode inputs change with each vector
        do_reset();
        for (int i = 0; i < 14; i++) begin
            adj = vt[i].a; sel = vt[i].sl; dir = vt[i].d;
            push(1'b0, vt[i].m, vt[i].s, 3'b000, vt[i].name);
            cyc(vt[i].t1, vt[i].t2, 1'b0, 1'b0);
        end

        // Lap hold, release, same-edge capture, reset mid-lap
        do_reset();
        ticks(9);
        push(1'b0, 0, 10, 3'b000, "lap_pre_10");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 10, 3'b010, "lap_capture");
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(4);
        push(1'b0, 0, 10, 3'b010, "lap_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 15, 3'b000, "lap_release");
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 16, 3'b010, "lap_tick_same_edge");
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 16, 3'b010, "lap_hold_tick");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 0, 16, 3'b110, "lap_pause");
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        pause = 1'b0;
        mid_reset("reset_mid_lap");
        push(1'b0, 0, 1, 3'b000, "tick_after_lap_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
